reg_file: RTL and testbench

MIPS general-purpose register file: the responder on the CPU's `register_*` port group (two read ports, one write port), plus one debug read port and a committed-write counter. It sits beside `mips_cpu`; `register_a1/a2/a3`, `register_we3` and `register_wd3` from the CPU drive `a1/a2/a3`, `we3` and `wd3` here, and `rd1/rd2` drive `register_rd1/rd2` back. Storage is 32×32-bit with `$0` hardwired to zero, `$sp`/`$gp` get their reset values, and writes are synchronous.

---
 rtl/mips_pkg.sv | 19 +
 rtl/reg_read_port.sv | 28 ++
 rtl/reg_file.sv | 99 +++++++++
 tb/tb_reg_file.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants: register-file geometry, datapath width, reset images.
// No logic; latency not applicable.
// No flow control; constants only.
package mips_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_GP   = 5'd28;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  // Default stack and global pointers loaded at reset.
  localparam logic [XLEN-1:0] SP_INIT_DEF = 32'h0000_7FFC;
  localparam logic [XLEN-1:0] GP_INIT_DEF = 32'h0000_1800;

endpackage

// File: rtl/reg_read_port.sv
// One register-file read port: $0 forcing plus optional write-to-read forwarding.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the port is always ready.
module reg_read_port
  import mips_pkg::*;
(
  input  logic [REG_AW-1:0]              addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
  input  logic                           we,
  input  logic [REG_AW-1:0]              wa,
  input  logic [XLEN-1:0]                wd,
  input  logic                           bypass_en,
  output logic [XLEN-1:0]                rd
);

  // Select the addressed flop, forward pending write data when enabled, and
  // force $0 last so neither the array nor a forward can make it non-zero.
  always_comb begin
    rd = regs[addr];
    if (bypass_en && we && (wa == addr)) begin
      rd = wd;
    end
    if (addr == REG_ZERO) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 register file: two CPU read ports, one write port, a debug read port, write counter.
// Latency: reads 0 cycles; writes land at the next rising edge.
// Backpressure: none; always ready, no stall outputs.
module reg_file
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEF,
  parameter logic [XLEN-1:0] GP_INIT = GP_INIT_DEF,
  parameter bit              BYPASS  = 1'b0,
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        a1,
  input  logic [4:0]        a2,
  input  logic [4:0]        a3,
  input  logic              we3,
  input  logic [31:0]       wd3,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  input  logic [4:0]        dbg_a,
  output logic [31:0]       dbg_rd,
  output logic [CNT_W-1:0]  write_count
);

  // $0 has no flop; only 1..31 are stored.
  logic [XLEN-1:0]               regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][XLEN-1:0] regs_view;
  logic                          wr_commit;

  // Writes to $0 are discarded and do not count as committed.
  assign wr_commit = we3 && (a3 != REG_ZERO);

  // Register storage: reset image has gp/sp preloaded; reset beats a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_GP] <= GP_INIT;
      regs_q[REG_SP] <= SP_INIT;
    end else if (wr_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (a3 == REG_AW'(i)) begin
          regs_q[i] <= wd3;
        end
      end
    end
  end

  // Committed-write counter, free-running wrap with no saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_count <= '0;
    end else if (wr_commit) begin
      write_count <= write_count + CNT_W'(1);
    end
  end

  // Flatten storage into the array view shared by all read ports; slot 0 is constant zero.
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  reg_read_port u_rd1 (
    .addr      (a1),
    .regs      (regs_view),
    .we        (we3),
    .wa        (a3),
    .wd        (wd3),
    .bypass_en (BYPASS),
    .rd        (rd1)
  );

  reg_read_port u_rd2 (
    .addr      (a2),
    .regs      (regs_view),
    .we        (we3),
    .wa        (a3),
    .wd        (wd3),
    .bypass_en (BYPASS),
    .rd        (rd2)
  );

  // Debug view always shows the committed flop contents.
  reg_read_port u_dbg (
    .addr      (dbg_a),
    .regs      (regs_view),
    .we        (we3),
    .wa        (a3),
    .wd        (wd3),
    .bypass_en (1'b0),
    .rd        (dbg_rd)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: three instances (default, forwarding, 4-bit counter) share one stimulus.
// Expected values are hand-computed constants.
// Inputs driven after the rising edge, outputs sampled 1ns after inputs settle.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, a3, dbg_a;
  logic        we3;
  logic [31:0] wd3;

  logic [31:0] rd1_n, rd2_n, dbg_n;
  logic [15:0] wc_n;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [15:0] wc_b;
  logic [31:0] rd1_c, rd2_c, dbg_c;
  logic [3:0]  wc_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut_n (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .rd1(rd1_n), .rd2(rd2_n), .dbg_a(dbg_a), .dbg_rd(dbg_n), .write_count(wc_n)
  );

  reg_file #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .rd1(rd1_b), .rd2(rd2_b), .dbg_a(dbg_a), .dbg_rd(dbg_b), .write_count(wc_b)
  );

  reg_file #(.CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .rd1(rd1_c), .rd2(rd2_c), .dbg_a(dbg_a), .dbg_rd(dbg_c), .write_count(wc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_img;

    reset = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; dbg_a = '0;
    tick();
    reset = 1'b0;
    #1;

    // Reset image sweep on the debug port
    for (int i = 0; i < 32; i++) begin
      dbg_a = i[4:0];
      #1;
      exp_img = (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_7FFC : 32'h0;
      chk($sformatf("reset_img[%0d]", i), dbg_n, exp_img);
    end
    chk("reset_wc_n", {16'h0, wc_n}, 32'h0);
    chk("reset_wc_b", {16'h0, wc_b}, 32'h0);
    chk("reset_wc_c", {28'h0, wc_c}, 32'h0);
    a1 = 5'd29; a2 = 5'd28;
    #1;
    chk("reset_rd1_sp", rd1_n, 32'h0000_7FFC);
    chk("reset_rd2_gp", rd2_n, 32'h0000_1800);

    // Plain write to $8: old value before the edge, new value after
    we3 = 1'b1; a3 = 5'd8; wd3 = 32'hDEAD_BEEF; a1 = 5'd8;
    #1;
    chk("pre_write_rd1", rd1_n, 32'h0);
    chk("pre_write_rd1_bypass", rd1_b, 32'hDEAD_BEEF);
    tick();
    we3 = 1'b0;
    #1;
    chk("post_write_rd1", rd1_n, 32'hDEAD_BEEF);
    chk("post_write_wc", {16'h0, wc_n}, 32'd1);

    // Write to $0 is dropped, not counted, and never forwarded
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd0;
    #1;
    chk("zero_bypass_rd1", rd1_b, 32'h0);
    chk("zero_bypass_rd2", rd2_b, 32'h0);
    tick();
    we3 = 1'b0;
    #1;
    chk("zero_rd1", rd1_n, 32'h0);
    chk("zero_wc", {16'h0, wc_n}, 32'd1);

    // Seed $5 with an old value
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hA5A5_0005;
    tick();
    // Same-register read/write, all ports at $5
    a1 = 5'd5; a2 = 5'd5; a3 = 5'd5; dbg_a = 5'd5; we3 = 1'b1; wd3 = 32'h1234_5678;
    #1;
    chk("bp_rd1", rd1_b, 32'h1234_5678);
    chk("bp_rd2", rd2_b, 32'h1234_5678);
    chk("bp_dbg_old", dbg_b, 32'hA5A5_0005);
    chk("nobp_rd1_old", rd1_n, 32'hA5A5_0005);
    chk("nobp_rd2_old", rd2_n, 32'hA5A5_0005);
    chk("bp_wc_before", {16'h0, wc_n}, 32'd2);
    tick();
    we3 = 1'b0;
    #1;
    chk("nobp_rd1_new", rd1_n, 32'h1234_5678);
    chk("dbg_new", dbg_n, 32'h1234_5678);
    chk("wc_after_bp", {16'h0, wc_n}, 32'd3);

    // Reset coincident with a write to $sp: reset wins
    reset = 1'b1; we3 = 1'b1; a3 = 5'd29; wd3 = 32'h0;
    tick();
    reset = 1'b0; we3 = 1'b0;
    dbg_a = 5'd29;
    #1;
    chk("rst_vs_write_sp", dbg_n, 32'h0000_7FFC);
    chk("rst_vs_write_wc", {16'h0, wc_n}, 32'h0);
    dbg_a = 5'd5;
    #1;
    chk("rst_clears_r5", dbg_n, 32'h0);
    dbg_a = 5'd8;
    #1;
    chk("rst_clears_r8", dbg_n, 32'h0);

    // 17 back-to-back writes to $3: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_0100 + 32'(i);
      tick();
    end
    we3 = 1'b0; dbg_a = 5'd3;
    #1;
    chk("wrap_wc_c", {28'h0, wc_c}, 32'd1);
    chk("wrap_wc_n", {16'h0, wc_n}, 32'd17);
    chk("wrap_r3_c", dbg_c, 32'h0000_0110);
    chk("wrap_r3_n", dbg_n, 32'h0000_0110);

    // Disabled write leaves state and count alone
    we3 = 1'b0; a3 = 5'd3; wd3 = 32'h0000_0BAD;
    tick();
    chk("no_we_r3", dbg_n, 32'h0000_0110);
    chk("no_we_wc", {16'h0, wc_n}, 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
